// File: rtl/data_memory_banked.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_banked
// Brief    : Windowed data RAM with post-reset clear, read strobe and fault flag
// Revision : 1.0
// ============================================================================
module data_memory_banked #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int BASE           = 128,
  parameter int LIMIT          = 223,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  input  logic              read,
  output logic [DATA_W-1:0] data_out,
  output logic              read_valid,
  output logic              ready,
  output logic              fault
);

  localparam int DEPTH = LIMIT - BASE + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clear_ptr_q, clear_ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              read_valid_q, read_valid_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;

  logic              lo_ok, hi_ok, in_range;
  logic [IDX_W-1:0]  index;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Window edges that coincide with the address space limits need no compare.
  generate
    if (BASE == 0) begin : g_lo_open
      assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign lo_ok = (address >= ADDR_W'(BASE));
    end
    if (LIMIT >= (2 ** ADDR_W) - 1) begin : g_hi_open
      assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
      assign hi_ok = (address <= ADDR_W'(LIMIT));
    end
  endgenerate

  assign in_range = lo_ok & hi_ok;
  assign index    = IDX_W'(address - ADDR_W'(BASE));

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    data_out_d   = data_out_q;
    read_valid_d = 1'b0;
    fault_d      = 1'b0;
    ready_d      = ready_q;
    mem_we       = 1'b0;
    mem_waddr    = index;
    mem_wdata    = data_in;
    case (state_q)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q;
        mem_wdata   = '0;
        fault_d     = write | read;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        if (write | read) begin
          if (!in_range) begin
            fault_d = 1'b1;
          end else if (write) begin
            // A simultaneous read is dropped silently: write wins.
            mem_we = 1'b1;
          end else begin
            data_out_d   = mem[index];
            read_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clear_ptr_q  <= '0;
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      data_out_q   <= data_out_d;
      read_valid_q <= read_valid_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;
  assign ready      = ready_q;
  assign fault      = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_banked
// Brief    : Directed self-checking bench for data_memory_banked
// Revision : 1.0
// ============================================================================
module tb_data_memory_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default-parameter instance
  logic       rst_a = 1'b0;
  logic [7:0] addr_a = '0, din_a = '0, dout_a;
  logic       wr_a = 1'b0, rd_a = 1'b0, rv_a, rdy_a, flt_a;

  data_memory_banked dut_a (
    .clock(clk), .reset(rst_a), .address(addr_a), .data_in(din_a),
    .write(wr_a), .read(rd_a), .data_out(dout_a), .read_valid(rv_a),
    .ready(rdy_a), .fault(flt_a)
  );

  // Wide instance without clear
  logic        rst_b = 1'b0;
  logic [9:0]  addr_b = '0;
  logic [15:0] din_b = '0, dout_b;
  logic        wr_b = 1'b0, rd_b = 1'b0, rv_b, rdy_b, flt_b;

  data_memory_banked #(
    .DATA_W(16), .ADDR_W(10), .BASE(512), .LIMIT(767), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clock(clk), .reset(rst_b), .address(addr_b), .data_in(din_b),
    .write(wr_b), .read(rd_b), .data_out(dout_b), .read_valid(rv_b),
    .ready(rdy_b), .fault(flt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    addr_a = a; rd_a = 1'b1;
    step();
    rd_a = 1'b0;
    check({tag, "_data"}, dout_a, exp);
    check({tag, "_rv"},   rv_a,   1'b1);
    check({tag, "_flt"},  flt_a,  1'b0);
    step();
    check({tag, "_rv_drop"}, rv_a, 1'b0);
  endtask

  task automatic a_write(input logic [7:0] a, input logic [7:0] d, input string tag);
    addr_a = a; din_a = d; wr_a = 1'b1;
    step();
    wr_a = 1'b0;
    check({tag, "_rv"},  rv_a,  1'b0);
    check({tag, "_flt"}, flt_a, 1'b0);
  endtask

  task automatic a_bad_write(input logic [7:0] a, input string tag);
    addr_a = a; din_a = 8'hEE; wr_a = 1'b1;
    step();
    wr_a = 1'b0;
    check({tag, "_flt"}, flt_a, 1'b1);
    check({tag, "_rv"},  rv_a,  1'b0);
    step();
    check({tag, "_flt_drop"}, flt_a, 1'b0);
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_ready", rdy_a, 1'b0);
    check("rst_dout",  dout_a, 8'h00);
    check("rst_rv",    rv_a, 1'b0);
    check("rst_flt",   flt_a, 1'b0);

    // Clear sequence, with a busy read on edge 10
    rst_a = 1'b1;
    addr_a = 8'd130;
    for (int e = 1; e <= 96; e++) begin
      rd_a = (e == 10);
      step();
      check($sformatf("clr_ready_e%0d", e), rdy_a, (e >= 96) ? 1'b1 : 1'b0);
      if (e == 10) begin
        check("busy_flt",  flt_a, 1'b1);
        check("busy_rv",   rv_a, 1'b0);
        check("busy_dout", dout_a, 8'h00);
      end
      if (e == 11) check("busy_flt_drop", flt_a, 1'b0);
    end
    rd_a = 1'b0;

    a_read(8'd128, 8'h00, "clr_rd128");
    a_read(8'd175, 8'h00, "clr_rd175");
    a_read(8'd223, 8'h00, "clr_rd223");

    // Window boundaries
    a_write(8'd128, 8'hA5, "wr128");
    a_write(8'd223, 8'h5A, "wr223");
    a_read(8'd128, 8'hA5, "rd128");
    a_read(8'd223, 8'h5A, "rd223");
    a_bad_write(8'd127, "wr127");
    a_bad_write(8'd224, "wr224");
    a_read(8'd128, 8'hA5, "rd128_again");
    addr_a = 8'd255; rd_a = 1'b1;
    step();
    rd_a = 1'b0;
    check("rd255_flt",  flt_a, 1'b1);
    check("rd255_rv",   rv_a, 1'b0);
    check("rd255_dout", dout_a, 8'hA5);

    // Simultaneous write and read: write wins, no pulse
    addr_a = 8'd150; din_a = 8'h3C; wr_a = 1'b1; rd_a = 1'b1;
    step();
    wr_a = 1'b0; rd_a = 1'b0;
    check("both_rv",   rv_a, 1'b0);
    check("both_flt",  flt_a, 1'b0);
    check("both_dout", dout_a, 8'hA5);
    step();
    check("both_hold", dout_a, 8'hA5);
    a_read(8'd150, 8'h3C, "rd150");

    // Reset in the middle of a clear
    a_write(8'd200, 8'h77, "wr200");
    a_read(8'd200, 8'h77, "rd200_pre");
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    for (int e = 1; e <= 49; e++) begin
      step();
      check($sformatf("clr2_ready_e%0d", e), rdy_a, 1'b0);
    end
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    check("midrst_ready", rdy_a, 1'b0);
    check("midrst_dout",  dout_a, 8'h00);
    for (int e = 1; e <= 96; e++) begin
      step();
      check($sformatf("clr3_ready_e%0d", e), rdy_a, (e >= 96) ? 1'b1 : 1'b0);
    end
    a_read(8'd200, 8'h00, "rd200_post");

    // Wide instance, no clear
    check("b_rst_ready", rdy_b, 1'b0);
    rst_b = 1'b1;
    step();
    check("b_ready", rdy_b, 1'b1);
    addr_b = 10'd767; din_b = 16'hBEEF; wr_b = 1'b1;
    step();
    wr_b = 1'b0;
    check("b_wr_flt", flt_b, 1'b0);
    rd_b = 1'b1;
    step();
    rd_b = 1'b0;
    check("b_rd_data", dout_b, 16'hBEEF);
    check("b_rd_rv",   rv_b, 1'b1);
    addr_b = 10'd768; rd_b = 1'b1;
    step();
    rd_b = 1'b0;
    check("b_768_flt",  flt_b, 1'b1);
    check("b_768_rv",   rv_b, 1'b0);
    check("b_768_dout", dout_b, 16'hBEEF);
    addr_b = 10'd511; wr_b = 1'b1;
    step();
    wr_b = 1'b0;
    check("b_511_flt", flt_b, 1'b1);
    step();
    check("b_flt_drop", flt_b, 1'b0);
    check("b_ready_hold", rdy_b, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_banked.md
Name: data_memory_banked

Overview:
Parametrised successor to the fixed 8-bit data RAM. It provides a windowed data memory of configurable width and address range. It adds:
- a hardware clear sequence after reset, with a ready flag;
- an explicit read strobe with a one-cycle read_valid pulse;
- a registered fault flag for out-of-window or busy accesses.

It sits on the processor data bus, beside the instruction ROM and I/O decode.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, bus address width in bits
BASE, 128, first bus address mapped to this memory
LIMIT, 223, last bus address mapped (inclusive); DEPTH = LIMIT-BASE+1; LIMIT >= BASE is mandatory
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear sequence (contents undefined)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset
address  input  ADDR_W  bus address
data_in  input  DATA_W  write data
write  input  1  write strobe, sampled on posedge
read  input  1  read strobe, sampled on posedge
data_out  output  DATA_W  registered read data
read_valid  output  1  one-cycle pulse: data_out updated by the read accepted on the previous edge
ready  output  1  memory accepting accesses
fault  output  1  one-cycle pulse: previous access rejected

Behaviour:
- Only one clock is used. Reset is synchronous and active-low: when reset=0 at a posedge, all registers take their reset values.
- Reset values are data_out=0, read_valid=0, fault=0, ready=0, clear_ptr=0.
- After reset, state=CLEAR if CLEAR_ON_RESET=1, else state=RUN with ready=1 one edge after reset deasserts.
- A posedge with reset=0 during CLEAR restarts the clear sequence from index 0. Reset is never ignored.
- Address decode: in_range = (address >= BASE) && (address <= LIMIT). index = address - BASE, with width clog2(DEPTH). The comparison uses full ADDR_W width, unsigned.
- CLEAR state:
  - Each posedge writes 0 to mem[clear_ptr], then increments clear_ptr.
  - The edge that writes index DEPTH-1 moves state to RUN and sets ready=1.
  - The clear therefore takes exactly DEPTH edges after reset deasserts.
- Access during CLEAR: any write=1 or read=1 is ignored. The memory is not written by the bus, data_out holds, read_valid=0, and fault=1 on the next edge.
- RUN state, decided per posedge in this priority:
  1. write=1, in_range: mem[index] <= data_in. Any simultaneous read is dropped, with read_valid=0 and no fault.
  2. write=0, read=1, in_range: data_out <= mem[index] and read_valid=1 for one cycle. Read latency is 1 edge.
  3. (write|read)=1, !in_range: no memory change, data_out holds, fault=1 for one cycle.
  4. No strobe: data_out holds, read_valid=0, fault=0.
- Read after write to the same index on consecutive edges returns the newly written data; no forwarding path is needed.
- data_out holds its last read value indefinitely. Only an accepted read or a reset changes it.
- read_valid and fault are never 1 in the same cycle.
- ready stays 1 in RUN until the next reset.
- Address at or beyond the window ends: BASE and LIMIT are both in range; BASE-1 and LIMIT+1 are faults. With BASE=0 the lower check is trivially true. Address values wider than the window never alias into memory.

Test Plan:
1. Clear sequence (defaults): hold reset=0 for 2 edges, release; count edges. Required: ready=0 through edge 95 and ready=1 after edge 96. Then read at 128, 175 and 223: each returns data_out=0x00 with read_valid pulsing once per read.
2. Write/read boundaries: write 0xA5 at 128 and 0x5A at 223; read both back. Required: 0xA5, then 0x5A, each with a 1-cycle read_valid. Write at 127 and at 224: fault pulses each time, no read_valid, and a later read of 128 still returns 0xA5.
3. Simultaneous strobes: write=1 and read=1 at 150 with data_in=0x3C. Required: read_valid=0 and fault=0. The next read of 150 returns 0x3C; data_out is unchanged until that read.
4. Busy access: issue a read at 130 during CLEAR (edge 10 after release). Required: fault=1 on the next cycle, read_valid=0, and data_out still 0x00.
5. Reset mid-clear: assert reset=0 at edge 50 of CLEAR, release. Required: ready=0 for 96 further edges, then ready=1. A read of 200 returns 0x00, even if 0x77 had been written to 200 before the earlier reset.
6. Parameter sweep: DATA_W=16, ADDR_W=10, BASE=512, LIMIT=767, CLEAR_ON_RESET=0. Required: ready=1 one edge after reset release. Write 0xBEEF at 767 and read it back as 0xBEEF. Address 768 faults.
